// File: rtl/lin_recur_gen.sv
`default_nettype none
// ============================================================================
// lin_recur_gen : linear-recurrence sequence generator with valid/ready output
// Rev 1.0
// ============================================================================
module lin_recur_gen #(
   parameter int WIDTH = 32,
   parameter int ORDER = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [ORDER*WIDTH-1:0] seed_i,
   input  logic [ORDER-1:0]       tap_i,
   input  logic [15:0]            count_i,
   input  logic                   sat_mode_i,
   input  logic                   ready_i,
   output logic [WIDTH-1:0]       seq_o,
   output logic                   valid_o,
   output logic [15:0]            idx_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   ovf_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] s [ORDER];
   logic [15:0]      terms_left;
   logic [ORDER-1:0] taps;
   logic             sat;
   logic [WIDTH+2:0] sum;
   logic             overflow;
   logic [WIDTH-1:0] next_term;
   logic             launch;
   logic             handshake;

   assign launch    = (state == IDLE) && start_i && !abort_i;
   assign handshake = (state == RUN) && ready_i;
   assign seq_o     = s[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // An abort overrides the DONE transition, so an aborted run never pulses done_o.
   always_comb begin
      state_nxt = state;
      valid_o   = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state)
         IDLE: begin
            if (start_i && !abort_i) begin
               state_nxt = (count_i == 16'd0) ? DONE : RUN;
            end
         end
         RUN: begin
            valid_o = 1'b1;
            busy_o  = 1'b1;
            if (abort_i) begin
               state_nxt = IDLE;
            end else if (ready_i && (terms_left == 16'd1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy_o    = 1'b1;
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Three guard bits hold the sum of up to eight full-width terms exactly.
   always_comb begin
      sum = '0;
      for (int k = 0; k < ORDER; k++) begin
         if (taps[k]) begin
            sum = sum + {3'b000, s[k]};
         end
      end
   end

   assign overflow  = |sum[WIDTH+2:WIDTH];
   assign next_term = (overflow && sat) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < ORDER; k++) begin
            s[k] <= '0;
         end
         idx_o      <= '0;
         ovf_o      <= 1'b0;
         terms_left <= '0;
         taps       <= '0;
         sat        <= 1'b0;
      end else if (launch) begin
         for (int k = 0; k < ORDER; k++) begin
            s[k] <= seed_i[k*WIDTH +: WIDTH];
         end
         idx_o      <= '0;
         ovf_o      <= 1'b0;
         terms_left <= count_i;
         taps       <= tap_i;
         sat        <= sat_mode_i;
      end else if (handshake) begin
         for (int k = 0; k < ORDER - 1; k++) begin
            s[k] <= s[k+1];
         end
         s[ORDER-1] <= next_term;
         idx_o      <= idx_o + 16'd1;
         terms_left <= terms_left - 16'd1;
         if (overflow) begin
            ovf_o <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lin_recur_gen.sv
`default_nettype none
// tb_lin_recur_gen : directed and randomized checks of lin_recur_gen against a
// behavioural model; DUT a is 32-bit/order 3, DUT b is 8-bit/order 2.
module tb_lin_recur_gen;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        abort    = 1'b0;
   logic        ready    = 1'b1;
   logic        sat_mode = 1'b0;
   logic [15:0] count    = '0;
   logic        start_a  = 1'b0;
   logic        start_b  = 1'b0;
   logic [95:0] seed_a   = '0;
   logic [15:0] seed_b   = '0;
   logic [2:0]  tap_a    = '0;
   logic [1:0]  tap_b    = '0;

   logic [31:0] seq_a;
   logic [15:0] idx_a;
   logic        valid_a, busy_a, done_a, ovf_a;
   logic [7:0]  seq_b;
   logic [15:0] idx_b;
   logic        valid_b, busy_b, done_b, ovf_b;

   always #5 clk = ~clk;

   lin_recur_gen #(.WIDTH(32), .ORDER(3)) dut_a (
      .clk(clk), .reset(reset), .start_i(start_a), .abort_i(abort),
      .seed_i(seed_a), .tap_i(tap_a), .count_i(count), .sat_mode_i(sat_mode),
      .ready_i(ready), .seq_o(seq_a), .valid_o(valid_a), .idx_o(idx_a),
      .busy_o(busy_a), .done_o(done_a), .ovf_o(ovf_a)
   );

   lin_recur_gen #(.WIDTH(8), .ORDER(2)) dut_b (
      .clk(clk), .reset(reset), .start_i(start_b), .abort_i(abort),
      .seed_i(seed_b), .tap_i(tap_b), .count_i(count), .sat_mode_i(sat_mode),
      .ready_i(ready), .seq_o(seq_b), .valid_o(valid_b), .idx_o(idx_b),
      .busy_o(busy_b), .done_o(done_b), .ovf_o(ovf_b)
   );

   int tests = 0;
   int fails = 0;

   // Behavioural model: one entry per DUT (0 = a, 1 = b); phase 0 idle, 1 emitting, 2 finished.
   longint unsigned ms [2][8];
   int              mw [2] = '{32, 8};
   int              mo [2] = '{3, 2};
   int              m_ph [2];
   int              m_idx [2];
   int              m_left [2];
   int              m_tap [2];
   bit              m_ovf [2];
   bit              m_sat [2];
   longint unsigned mq0 [$];
   longint unsigned mq1 [$];

   longint unsigned exp034 [16] = '{1, 1, 1, 2, 2, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0};
   longint unsigned exp_fib [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 0};

   int vcnt [2];
   int dcnt [2];
   int bcnt [2];

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 8; k++) ms[d][k] = 0;
         m_ph[d] = 0; m_idx[d] = 0; m_left[d] = 0; m_tap[d] = 0;
         m_ovf[d] = 1'b0; m_sat[d] = 1'b0;
      end
   endtask

   task automatic model_step(int d, bit st, logic [95:0] sv, logic [7:0] tp);
      longint unsigned mask, sum, term, t;
      int w, n;
      w = mw[d];
      n = mo[d];
      mask = (64'd1 << w) - 64'd1;
      if (m_ph[d] == 0) begin
         if (st && !abort) begin
            for (int k = 0; k < n; k++) begin
               t = 64'(sv >> (k * w));
               ms[d][k] = t & mask;
            end
            m_idx[d] = 0; m_ovf[d] = 1'b0; m_left[d] = int'(count);
            m_tap[d] = int'(tp); m_sat[d] = sat_mode;
            m_ph[d] = (count == 16'd0) ? 2 : 1;
         end
      end else if (m_ph[d] == 1) begin
         if (ready) begin
            sum = 0;
            for (int k = 0; k < n; k++) if (m_tap[d][k]) sum += ms[d][k];
            if (sum > mask) begin
               m_ovf[d] = 1'b1;
               term = m_sat[d] ? mask : (sum & mask);
            end else begin
               term = sum;
            end
            if (d == 0) mq0.push_back(ms[d][0]); else mq1.push_back(ms[d][0]);
            for (int k = 0; k < n - 1; k++) ms[d][k] = ms[d][k+1];
            ms[d][n-1] = term;
            m_idx[d] = (m_idx[d] + 1) & 16'hFFFF;
            m_left[d] = m_left[d] - 1;
            if (m_left[d] == 0) m_ph[d] = 2;
         end
         if (abort) m_ph[d] = 0;
      end else begin
         m_ph[d] = 0;
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         model_reset();
      end else begin
         model_step(0, start_a, seed_a, {5'b0, tap_a});
         model_step(1, start_b, {80'b0, seed_b}, {6'b0, tap_b});
      end
   end

   task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         cmp("a.valid", valid_a, m_ph[0] == 1);
         cmp("a.busy",  busy_a,  m_ph[0] != 0);
         cmp("a.done",  done_a,  m_ph[0] == 2);
         cmp("a.seq",   seq_a,   ms[0][0]);
         cmp("a.idx",   idx_a,   m_idx[0]);
         cmp("a.ovf",   ovf_a,   m_ovf[0]);
         cmp("b.valid", valid_b, m_ph[1] == 1);
         cmp("b.busy",  busy_b,  m_ph[1] != 0);
         cmp("b.done",  done_b,  m_ph[1] == 2);
         cmp("b.seq",   seq_b,   ms[1][0]);
         cmp("b.idx",   idx_b,   m_idx[1]);
         cmp("b.ovf",   ovf_b,   m_ovf[1]);
         if (valid_a) vcnt[0]++;
         if (done_a)  dcnt[0]++;
         if (busy_a)  bcnt[0]++;
         if (valid_b) vcnt[1]++;
         if (done_b)  dcnt[1]++;
         if (busy_b)  bcnt[1]++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(int d, logic [95:0] sv, logic [7:0] tp, logic [15:0] cnt, logic sat);
      seed_a   = sv;
      seed_b   = sv[15:0];
      tap_a    = tp[2:0];
      tap_b    = tp[1:0];
      count    = cnt;
      sat_mode = sat;
      if (d == 0) start_a = 1'b1; else start_b = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic bound_chk(int d, string nm);
      if (m_ph[d] != 0) begin
         tests++;
         fails++;
         $display("FAIL %s timeout: dut%0d still busy, required idle", nm, d);
      end
   endtask

   task automatic run_idle(int d, int maxc, string nm);
      int c;
      c = 0;
      while (m_ph[d] != 0 && c < maxc) begin
         tick();
         c++;
      end
      bound_chk(d, nm);
   endtask

   task automatic check_seq(string nm, int d, longint unsigned e [16], int n);
      int sz;
      sz = (d == 0) ? mq0.size() : mq1.size();
      cmp({nm, ".len"}, sz, n);
      for (int i = 0; i < n && i < sz; i++)
         cmp($sformatf("%s[%0d]", nm, i), (d == 0) ? mq0[i] : mq1[i], e[i]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          c, d, stall, b0, v0, d0;
      logic [95:0] sv;

      repeat (2) @(posedge clk);
      #1;
      cmp("rst.seq_a", seq_a, 0);   cmp("rst.valid_a", valid_a, 0);
      cmp("rst.idx_a", idx_a, 0);   cmp("rst.busy_a", busy_a, 0);
      cmp("rst.done_a", done_a, 0); cmp("rst.ovf_a", ovf_a, 0);
      cmp("rst.seq_b", seq_b, 0);   cmp("rst.valid_b", valid_b, 0);
      reset = 1'b0;
      tick();

      // Tribonacci-like order 3 with taps s0+s1
      mq0.delete();
      d0 = dcnt[0];
      launch(0, {32'd1, 32'd1, 32'd1}, 8'b011, 16'd8, 1'b0);
      run_idle(0, 40, "r034");
      check_seq("r034", 0, exp034, 8);
      cmp("r034.done_pulses", dcnt[0] - d0, 1);

      // Fibonacci with a three-cycle stall at index 4
      mq1.delete();
      launch(1, 96'h0100, 8'b11, 16'd10, 1'b0);
      stall = 0;
      c = 0;
      while (m_ph[1] != 0 && c < 60) begin
         if (m_ph[1] == 1 && m_idx[1] == 4 && stall < 3) begin
            ready = 1'b0;
            stall++;
         end else begin
            ready = 1'b1;
         end
         tick();
         c++;
         if (!ready) begin
            cmp("r035.hold_seq", seq_b, 3);
            cmp("r035.hold_idx", idx_b, 4);
         end
      end
      ready = 1'b1;
      bound_chk(1, "r035");
      check_seq("r035", 1, exp_fib, 10);

      // 8-bit Fibonacci overflow: wrap then saturate, then a clean run clears ovf
      mq1.delete();
      launch(1, 96'h0100, 8'b11, 16'd15, 1'b0);
      run_idle(1, 40, "r036w");
      check_seq("r036w", 1, exp_fib, 15);
      cmp("r036w.ovf", ovf_b, 1);
      mq1.delete();
      launch(1, 96'h0100, 8'b11, 16'd15, 1'b1);
      cmp("r036s.ovf_cleared", ovf_b, 0);
      run_idle(1, 40, "r036s");
      cmp("r036s.len", mq1.size(), 15);
      if (mq1.size() == 15) begin
         cmp("r036s.idx13", mq1[13], 233);
         cmp("r036s.idx14", mq1[14], 255);
      end
      cmp("r036s.ovf", ovf_b, 1);
      launch(1, 96'h0100, 8'b11, 16'd3, 1'b0);
      run_idle(1, 20, "r036c");
      cmp("r036c.ovf", ovf_b, 0);

      // Zero-length run, then start+abort together in idle
      b0 = bcnt[0]; v0 = vcnt[0]; d0 = dcnt[0];
      launch(0, {32'd1, 32'd1, 32'd1}, 8'b011, 16'd0, 1'b0);
      tick(); tick(); tick();
      cmp("r037.busy_cycles", bcnt[0] - b0, 1);
      cmp("r037.done_pulses", dcnt[0] - d0, 1);
      cmp("r037.valid_cycles", vcnt[0] - v0, 0);
      b0 = bcnt[0];
      abort = 1'b1;
      start_a = 1'b1;
      count = 16'd5;
      tick();
      start_a = 1'b0;
      abort = 1'b0;
      tick(); tick();
      cmp("r037.start_abort_busy", bcnt[0] - b0, 0);

      // Abort at index 3; the handshake in the abort cycle still lands
      d0 = dcnt[0];
      launch(0, {32'd1, 32'd1, 32'd1}, 8'b011, 16'd8, 1'b0);
      c = 0;
      while (!(m_ph[0] == 1 && m_idx[0] == 3) && c < 20) begin
         tick();
         c++;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      cmp("r038a.busy", busy_a, 0);
      cmp("r038a.valid", valid_a, 0);
      cmp("r038a.idx", idx_a, 4);
      cmp("r038a.seq", seq_a, 2);
      tick(); tick();
      cmp("r038a.done_pulses", dcnt[0] - d0, 0);

      // Reset at index 5, then a fresh run reproduces the sequence
      launch(1, 96'h0100, 8'b11, 16'd10, 1'b0);
      c = 0;
      while (!(m_ph[1] == 1 && m_idx[1] == 5) && c < 20) begin
         tick();
         c++;
      end
      d0 = dcnt[1];
      reset = 1'b1;
      #1;
      cmp("r038r.seq", seq_b, 0);   cmp("r038r.valid", valid_b, 0);
      cmp("r038r.idx", idx_b, 0);   cmp("r038r.busy", busy_b, 0);
      cmp("r038r.done", done_b, 0); cmp("r038r.ovf", ovf_b, 0);
      tick();
      reset = 1'b0;
      tick();
      cmp("r038r.no_done", dcnt[1] - d0, 0);
      mq1.delete();
      launch(1, 96'h0100, 8'b11, 16'd10, 1'b0);
      run_idle(1, 40, "r038r");
      check_seq("r038r", 1, exp_fib, 10);

      // Randomized runs with back-pressure, aborts and input churn mid-run
      for (int r = 0; r < 40; r++) begin
         d = r % 2;
         sv = {$urandom, $urandom, $urandom};
         if ($urandom_range(0, 1) == 1) sv = sv & {3{32'h0000_00ff}};
         launch(d, sv, 8'($urandom), 16'($urandom_range(0, 24)), 1'($urandom_range(0, 1)));
         c = 0;
         while (m_ph[d] != 0 && c < 300) begin
            ready    = ($urandom_range(0, 9) < 7);
            abort    = ($urandom_range(0, 39) == 0);
            seed_a   = {$urandom, $urandom, $urandom};
            seed_b   = 16'($urandom);
            tap_a    = 3'($urandom);
            tap_b    = 2'($urandom);
            sat_mode = 1'($urandom);
            count    = 16'($urandom);
            if (d == 0) start_a = ($urandom_range(0, 4) == 0);
            else        start_b = ($urandom_range(0, 4) == 0);
            tick();
            c++;
         end
         start_a = 1'b0;
         start_b = 1'b0;
         abort   = 1'b0;
         ready   = 1'b1;
         bound_chk(d, "rand");
         tick();
      end

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
